// File: rtl/directory_controller.sv
// Directory-based MSI-style coherence controller: one request at a time, with
// per-block state and sharer vector and a single outstanding coherence command.
module directory_controller #(
    parameter  int NBLK   = 4,
    parameter  int NCACHE = 2,
    localparam int AW     = (NBLK > 1) ? $clog2(NBLK) : 1,
    localparam int SW     = (NCACHE > 1) ? $clog2(NCACHE) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [1:0]    ReqType,
    input  logic [SW-1:0] ReqSrc,
    input  logic [AW-1:0] ReqAddr,
    output logic          CmdValid,
    output logic [1:0]    CmdType,
    output logic [SW-1:0] CmdDst,
    output logic [AW-1:0] CmdAddr,
    input  logic          CmdAck,
    output logic          RespValid,
    output logic [1:0]    RespType,
    output logic [SW-1:0] RespDst,
    output logic [AW-1:0] RespAddr,
    output logic [1:0]    DirState
);

    // state  | meaning
    // IDLE   | ready for a request
    // LOOKUP | read entry, decide next entry value and whether a command is needed
    // CMD    | coherence command outstanding, waiting for CmdAck
    // REPLY  | one-cycle response pulse, entry written on entry to this state
    typedef enum logic [1:0] {IDLE, LOOKUP, CMD, REPLY} fsm_t;

    localparam logic [1:0] ST_UNC   = 2'b00;
    localparam logic [1:0] ST_SH    = 2'b01;
    localparam logic [1:0] ST_EX    = 2'b10;
    localparam logic [1:0] REQ_RD   = 2'b01;
    localparam logic [1:0] REQ_WB   = 2'b11;
    localparam logic [1:0] CMD_INV  = 2'b01;
    localparam logic [1:0] CMD_FET  = 2'b10;
    localparam logic [1:0] CMD_FINV = 2'b11;
    localparam logic [1:0] RSP_SH   = 2'b01;
    localparam logic [1:0] RSP_EX   = 2'b10;
    localparam logic [1:0] RSP_WB   = 2'b11;

    function automatic logic [SW-1:0] first_set(input logic [NCACHE-1:0] v);
        first_set = '0;
        for (int i = NCACHE - 1; i >= 0; i--) begin
            if (v[i]) first_set = SW'(i);
        end
    endfunction

    fsm_t                          fsm_q, fsm_d;
    logic [1:0]                    rtype_q, rtype_d;
    logic [SW-1:0]                 src_q, src_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [1:0]                    nst_q, nst_d;
    logic [NCACHE-1:0]             nshr_q, nshr_d;
    logic [1:0]                    rsp_plan_q, rsp_plan_d;
    logic [NCACHE-1:0]             mask_q, mask_d;
    logic                          req_ready_q, req_ready_d;
    logic                          cmd_valid_q, cmd_valid_d;
    logic [1:0]                    cmd_type_q, cmd_type_d;
    logic [SW-1:0]                 cmd_dst_q, cmd_dst_d;
    logic [AW-1:0]                 cmd_addr_q, cmd_addr_d;
    logic                          resp_valid_q, resp_valid_d;
    logic [1:0]                    resp_type_q, resp_type_d;
    logic [SW-1:0]                 resp_dst_q, resp_dst_d;
    logic [AW-1:0]                 resp_addr_q, resp_addr_d;
    logic [1:0]                    dir_state_q, dir_state_d;
    logic [NBLK-1:0][1:0]          dir_st_q, dir_st_d;
    logic [NBLK-1:0][NCACHE-1:0]   dir_shr_q, dir_shr_d;

    logic [1:0]        cur_st;
    logic [NCACHE-1:0] cur_shr;
    logic [NCACHE-1:0] src_bit;
    logic              is_owner;
    logic [1:0]        lk_st;
    logic [NCACHE-1:0] lk_shr;
    logic [1:0]        lk_rsp;
    logic [1:0]        lk_cmd;
    logic [NCACHE-1:0] lk_mask;
    logic [NCACHE-1:0] rem_mask;
    logic [1:0]        rep_st;
    logic [NCACHE-1:0] rep_shr;
    logic [1:0]        rep_rsp;
    logic              go_reply;

    assign cur_st   = dir_st_q[addr_q];
    assign cur_shr  = dir_shr_q[addr_q];
    assign src_bit  = NCACHE'(1) << src_q;
    assign is_owner = (cur_st == ST_EX) && ((cur_shr & src_bit) != '0);
    assign rem_mask = mask_q & ~(NCACHE'(1) << cmd_dst_q);

    // The reply can come straight from LOOKUP or later from CMD, so select
    // between the live decision and the copy saved when the command went out.
    assign rep_st  = (fsm_q == LOOKUP) ? lk_st  : nst_q;
    assign rep_shr = (fsm_q == LOOKUP) ? lk_shr : nshr_q;
    assign rep_rsp = (fsm_q == LOOKUP) ? lk_rsp : rsp_plan_q;

    always_comb begin
        lk_st   = cur_st;
        lk_shr  = cur_shr;
        lk_rsp  = RSP_EX;
        lk_cmd  = CMD_INV;
        lk_mask = '0;
        if (rtype_q == REQ_WB) begin
            lk_rsp = RSP_WB;
            if (is_owner) begin
                lk_st  = ST_UNC;
                lk_shr = '0;
            end
        end else if (is_owner) begin
            lk_rsp = RSP_EX;
        end else if (rtype_q == REQ_RD) begin
            lk_rsp = RSP_SH;
            lk_st  = ST_SH;
            if (cur_st == ST_EX) begin
                lk_shr  = cur_shr | src_bit;
                lk_mask = cur_shr;
                lk_cmd  = CMD_FET;
            end else if (cur_st == ST_SH) begin
                lk_shr = cur_shr | src_bit;
            end else begin
                lk_shr = src_bit;
            end
        end else begin
            lk_rsp = RSP_EX;
            lk_st  = ST_EX;
            lk_shr = src_bit;
            if (cur_st == ST_EX) begin
                lk_mask = cur_shr;
                lk_cmd  = CMD_FINV;
            end else if (cur_st == ST_SH) begin
                lk_mask = cur_shr & ~src_bit;
                lk_cmd  = CMD_INV;
            end
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        rtype_d      = rtype_q;
        src_d        = src_q;
        addr_d       = addr_q;
        nst_d        = nst_q;
        nshr_d       = nshr_q;
        rsp_plan_d   = rsp_plan_q;
        mask_d       = mask_q;
        req_ready_d  = req_ready_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_type_d   = cmd_type_q;
        cmd_dst_d    = cmd_dst_q;
        cmd_addr_d   = cmd_addr_q;
        resp_valid_d = 1'b0;
        resp_type_d  = resp_type_q;
        resp_dst_d   = resp_dst_q;
        resp_addr_d  = resp_addr_q;
        dir_state_d  = dir_state_q;
        dir_st_d     = dir_st_q;
        dir_shr_d    = dir_shr_q;
        go_reply     = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (ReqValid && (ReqType != 2'b00)) begin
                    rtype_d     = ReqType;
                    src_d       = ReqSrc;
                    addr_d      = ReqAddr;
                    req_ready_d = 1'b0;
                    fsm_d       = LOOKUP;
                end
            end
            LOOKUP: begin
                nst_d      = lk_st;
                nshr_d     = lk_shr;
                rsp_plan_d = lk_rsp;
                if (lk_mask != '0) begin
                    mask_d      = lk_mask;
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = lk_cmd;
                    cmd_dst_d   = first_set(lk_mask);
                    cmd_addr_d  = addr_q;
                    fsm_d       = CMD;
                end else begin
                    go_reply = 1'b1;
                end
            end
            CMD: begin
                // Several sharers are invalidated one after another; dst only
                // moves on once the current target has acknowledged.
                if (CmdAck) begin
                    mask_d = rem_mask;
                    if (rem_mask != '0) begin
                        cmd_dst_d = first_set(rem_mask);
                    end else begin
                        cmd_valid_d = 1'b0;
                        go_reply    = 1'b1;
                    end
                end
            end
            REPLY: begin
                req_ready_d = 1'b1;
                fsm_d       = IDLE;
            end
            default: fsm_d = IDLE;
        endcase

        if (go_reply) begin
            fsm_d             = REPLY;
            resp_valid_d      = 1'b1;
            resp_type_d       = rep_rsp;
            resp_dst_d        = src_q;
            resp_addr_d       = addr_q;
            dir_state_d       = rep_st;
            dir_st_d[addr_q]  = rep_st;
            dir_shr_d[addr_q] = rep_shr;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            fsm_q        <= IDLE;
            rtype_q      <= '0;
            src_q        <= '0;
            addr_q       <= '0;
            nst_q        <= '0;
            nshr_q       <= '0;
            rsp_plan_q   <= '0;
            mask_q       <= '0;
            req_ready_q  <= 1'b1;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= '0;
            cmd_dst_q    <= '0;
            cmd_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_type_q  <= '0;
            resp_dst_q   <= '0;
            resp_addr_q  <= '0;
            dir_state_q  <= '0;
            dir_st_q     <= '0;
            dir_shr_q    <= '0;
        end else begin
            fsm_q        <= fsm_d;
            rtype_q      <= rtype_d;
            src_q        <= src_d;
            addr_q       <= addr_d;
            nst_q        <= nst_d;
            nshr_q       <= nshr_d;
            rsp_plan_q   <= rsp_plan_d;
            mask_q       <= mask_d;
            req_ready_q  <= req_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            cmd_dst_q    <= cmd_dst_d;
            cmd_addr_q   <= cmd_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_type_q  <= resp_type_d;
            resp_dst_q   <= resp_dst_d;
            resp_addr_q  <= resp_addr_d;
            dir_state_q  <= dir_state_d;
            dir_st_q     <= dir_st_d;
            dir_shr_q    <= dir_shr_d;
        end
    end

    assign ReqReady  = req_ready_q;
    assign CmdValid  = cmd_valid_q;
    assign CmdType   = cmd_type_q;
    assign CmdDst    = cmd_dst_q;
    assign CmdAddr   = cmd_addr_q;
    assign RespValid = resp_valid_q;
    assign RespType  = resp_type_q;
    assign RespDst   = resp_dst_q;
    assign RespAddr  = resp_addr_q;
    assign DirState  = dir_state_q;

endmodule

// File: tb/tb_directory_controller.sv
// Directed bench for directory_controller; expected replies are queued when a
// request is driven and checked when RespValid appears.
module tb_directory_controller;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       ReqValid;
    logic       ReqReady;
    logic [1:0] ReqType;
    logic [0:0] ReqSrc;
    logic [1:0] ReqAddr;
    logic       CmdValid;
    logic [1:0] CmdType;
    logic [0:0] CmdDst;
    logic [1:0] CmdAddr;
    logic       CmdAck;
    logic       RespValid;
    logic [1:0] RespType;
    logic [0:0] RespDst;
    logic [1:0] RespAddr;
    logic [1:0] DirState;

    directory_controller #(.NBLK(4), .NCACHE(2)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqType  (ReqType),
        .ReqSrc   (ReqSrc),
        .ReqAddr  (ReqAddr),
        .CmdValid (CmdValid),
        .CmdType  (CmdType),
        .CmdDst   (CmdDst),
        .CmdAddr  (CmdAddr),
        .CmdAck   (CmdAck),
        .RespValid(RespValid),
        .RespType (RespType),
        .RespDst  (RespDst),
        .RespAddr (RespAddr),
        .DirState (DirState)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] rt;
        logic       dst;
        logic [1:0] addr;
        logic [1:0] ds;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge; returns at the negedge after acceptance.
    task automatic send(input string tag, input logic [1:0] t, input logic s, input logic [1:0] a,
                        input bit push, input logic [1:0] ert, input logic [1:0] eds);
        int   n = 0;
        exp_t e;
        while (ReqReady !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk({tag, "_ready"}, 8'(ReqReady), 8'd1);
        if (push) begin
            e.rt = ert; e.dst = s; e.addr = a; e.ds = eds;
            sb.push_back(e);
        end
        ReqValid = 1'b1; ReqType = t; ReqSrc = s; ReqAddr = a;
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0; ReqType = 2'b00;
    endtask

    task automatic get_resp(input string tag, input int exp_wait, input bit exp_no_cmd);
        int   w = 0;
        bit   saw = 1'b0;
        exp_t e;
        while (RespValid !== 1'b1 && w < 20) begin
            if (CmdValid === 1'b1) saw = 1'b1;
            @(negedge Clock);
            w++;
        end
        chk({tag, "_valid"}, 8'(RespValid), 8'd1);
        chk({tag, "_latency"}, 8'(w), 8'(exp_wait));
        if (exp_no_cmd) chk({tag, "_nocmd"}, 8'(saw), 8'd0);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb observed=reply expected=no reply", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_type"}, 8'(RespType), 8'(e.rt));
            chk({tag, "_dst"}, 8'(RespDst), 8'(e.dst));
            chk({tag, "_addr"}, 8'(RespAddr), 8'(e.addr));
            chk({tag, "_dirstate"}, 8'(DirState), 8'(e.ds));
        end
        @(negedge Clock);
        chk({tag, "_pulse"}, 8'(RespValid), 8'd0);
    endtask

    // Wait for a command, keep it stalled for `hold` cycles while poking
    // ReqValid, then acknowledge; returns at the negedge after the ack edge.
    task automatic do_cmd(input string tag, input logic [1:0] t, input logic d, input logic [1:0] a,
                          input int hold);
        int w = 0;
        while (CmdValid !== 1'b1 && w < 20) begin
            @(negedge Clock);
            w++;
        end
        chk({tag, "_cmdvalid"}, 8'(CmdValid), 8'd1);
        chk({tag, "_cmdtype"}, 8'(CmdType), 8'(t));
        chk({tag, "_cmddst"}, 8'(CmdDst), 8'(d));
        chk({tag, "_cmdaddr"}, 8'(CmdAddr), 8'(a));
        chk({tag, "_busy"}, 8'(ReqReady), 8'd0);
        ReqValid = 1'b1; ReqType = 2'b01; ReqSrc = ~d; ReqAddr = a + 2'd1;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            chk({tag, "_hold_valid"}, 8'(CmdValid), 8'd1);
            chk({tag, "_hold_type"}, 8'(CmdType), 8'(t));
            chk({tag, "_hold_dst"}, 8'(CmdDst), 8'(d));
        end
        ReqValid = 1'b0; ReqType = 2'b00;
        CmdAck = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        CmdAck = 1'b0;
        chk({tag, "_cmd_drop"}, 8'(CmdValid), 8'd0);
    endtask

    initial begin
        int w;
        Reset = 1'b0; ReqValid = 1'b0; ReqType = 2'b00; ReqSrc = 1'b0; ReqAddr = 2'd0; CmdAck = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_ready", 8'(ReqReady), 8'd1);
        chk("rst_cmdvalid", 8'(CmdValid), 8'd0);
        chk("rst_respvalid", 8'(RespValid), 8'd0);
        chk("rst_cmdtype", 8'(CmdType), 8'd0);
        chk("rst_resptype", 8'(RespType), 8'd0);
        chk("rst_dirstate", 8'(DirState), 8'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Stray ack and a type-00 request in IDLE must both be ignored.
        CmdAck = 1'b1; ReqValid = 1'b1; ReqType = 2'b00;
        @(posedge Clock);
        @(negedge Clock);
        CmdAck = 1'b0; ReqValid = 1'b0;
        chk("idle_ignore_ready", 8'(ReqReady), 8'd1);
        chk("idle_ignore_resp", 8'(RespValid), 8'd0);
        chk("idle_ignore_cmd", 8'(CmdValid), 8'd0);

        send("rm_unc", 2'b01, 1'b0, 2'd2, 1'b1, 2'b01, 2'b01);
        get_resp("rm_unc", 1, 1'b1);

        send("rm_a1", 2'b01, 1'b0, 2'd1, 1'b1, 2'b01, 2'b01);
        get_resp("rm_a1", 1, 1'b1);
        send("wm_inv", 2'b10, 1'b1, 2'd1, 1'b1, 2'b10, 2'b10);
        do_cmd("wm_inv", 2'b01, 1'b0, 2'd1, 3);
        get_resp("wm_inv", 0, 1'b0);
        send("owner_rm", 2'b01, 1'b1, 2'd1, 1'b1, 2'b10, 2'b10);
        get_resp("owner_rm", 1, 1'b1);

        send("wm_a3", 2'b10, 1'b1, 2'd3, 1'b1, 2'b10, 2'b10);
        get_resp("wm_a3", 1, 1'b1);
        send("rm_fetch", 2'b01, 1'b0, 2'd3, 1'b1, 2'b01, 2'b01);
        do_cmd("rm_fetch", 2'b10, 1'b1, 2'd3, 2);
        get_resp("rm_fetch", 0, 1'b0);
        send("wm_a3_inv", 2'b10, 1'b0, 2'd3, 1'b1, 2'b10, 2'b10);
        do_cmd("wm_a3_inv", 2'b01, 1'b1, 2'd3, 0);
        get_resp("wm_a3_inv", 0, 1'b0);

        send("rm_sh_add", 2'b01, 1'b1, 2'd2, 1'b1, 2'b01, 2'b01);
        get_resp("rm_sh_add", 1, 1'b1);
        send("wm_a2_inv", 2'b10, 1'b0, 2'd2, 1'b1, 2'b10, 2'b10);
        do_cmd("wm_a2_inv", 2'b01, 1'b1, 2'd2, 1);
        get_resp("wm_a2_inv", 0, 1'b0);
        send("wm_finv", 2'b10, 1'b1, 2'd2, 1'b1, 2'b10, 2'b10);
        do_cmd("wm_finv", 2'b11, 1'b0, 2'd2, 1);
        get_resp("wm_finv", 0, 1'b0);

        send("rm_a0", 2'b01, 1'b0, 2'd0, 1'b1, 2'b01, 2'b01);
        get_resp("rm_a0", 1, 1'b1);
        send("wm_sole", 2'b10, 1'b0, 2'd0, 1'b1, 2'b10, 2'b10);
        get_resp("wm_sole", 1, 1'b1);
        send("wb_owner", 2'b11, 1'b0, 2'd0, 1'b1, 2'b11, 2'b00);
        get_resp("wb_owner", 1, 1'b1);
        send("wb_stale_unc", 2'b11, 1'b1, 2'd0, 1'b1, 2'b11, 2'b00);
        get_resp("wb_stale_unc", 1, 1'b1);
        send("wm_after_wb", 2'b10, 1'b1, 2'd0, 1'b1, 2'b10, 2'b10);
        get_resp("wm_after_wb", 1, 1'b1);
        send("wb_stale_ex", 2'b11, 1'b0, 2'd0, 1'b1, 2'b11, 2'b10);
        get_resp("wb_stale_ex", 1, 1'b1);
        send("owner_rm_a0", 2'b01, 1'b1, 2'd0, 1'b1, 2'b10, 2'b10);
        get_resp("owner_rm_a0", 1, 1'b1);

        // Reset while a fetch is outstanding drops the request without a reply.
        send("rst_mid", 2'b01, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00);
        w = 0;
        while (CmdValid !== 1'b1 && w < 20) begin
            @(negedge Clock);
            w++;
        end
        chk("rst_mid_cmdvalid", 8'(CmdValid), 8'd1);
        chk("rst_mid_cmdtype", 8'(CmdType), 8'b10);
        chk("rst_mid_cmddst", 8'(CmdDst), 8'd1);
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_mid_cmdvalid_off", 8'(CmdValid), 8'd0);
        chk("rst_mid_ready", 8'(ReqReady), 8'd1);
        chk("rst_mid_resp", 8'(RespValid), 8'd0);
        chk("rst_mid_dirstate", 8'(DirState), 8'd0);
        Reset = 1'b1;
        @(negedge Clock);
        send("rm_after_rst", 2'b01, 1'b0, 2'd1, 1'b1, 2'b01, 2'b01);
        get_resp("rm_after_rst", 1, 1'b1);
        send("wm_a3_after_rst", 2'b10, 1'b1, 2'd3, 1'b1, 2'b10, 2'b10);
        get_resp("wm_a3_after_rst", 1, 1'b1);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
